boot_sequencer: RTL
===================

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL have parameter N_WORDS, default 16, meaning the number of program words loaded per boot (1..16).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, meaning the max clk cycles to wait for done_in per word.
REQ-003 SHALL have parameter HOLD_CYC, default 4, meaning the number of clk cycles the core is held in reset before loading.
REQ-004 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: start  in  1  one-cycle request to begin a boot sequence; honoured only in IDLE.
REQ-007 SHALL have port: rom_addr  out  4  program-image word address.
REQ-008 SHALL have port: rom_data  in  8  image word; valid exactly 1 cycle after rom_addr changes.
REQ-009 SHALL have port: mode_out  out  2  processor mode select.
REQ-010 SHALL have port: mosi_out  out  1  serial program bit to processor.
REQ-011 SHALL have port: done_in  in  1  processor per-word acknowledge, level, synchronous to clk.
REQ-012 SHALL have port: core_rst_n  out  1  processor reset, active-low.
REQ-013 SHALL have port: busy  out  1  high in every state except IDLE, RUN and ERR.
REQ-014 SHALL have port: done_out  out  1  one-cycle pulse on entry to RUN.
REQ-015 SHALL have port: err  out  1  high while in ERR.

Function
REQ-016 SHALL implement FSM states IDLE, HOLD, FETCH, SHIFT, ACK, RUN, ERR.
REQ-017 IDLE: mode_out=MODE_IDLE, core_rst_n=0; start=1 -> HOLD, with the hold counter cleared.
REQ-018 HOLD: core_rst_n=0, mode_out=MODE_LOAD, rom_addr=0; after exactly HOLD_CYC cycles -> FETCH.
REQ-019 HOLD: core_rst_n SHALL go to 1 on FETCH entry; the core is out of reset throughout loading.
REQ-020 FETCH: 1 cycle; rom_data is registered into an 8-bit shift register at the end of the cycle -> SHIFT.
REQ-021 SHIFT: drives mosi_out = shift_reg[7], MSB first, one bit per clk for exactly 8 cycles, then -> ACK.
REQ-022 Outside SHIFT, mosi_out SHALL be 0.
REQ-023 ACK: 8-bit timeout counter increments each cycle.
REQ-024 ACK: done_in=1 -> if word index = N_WORDS-1 then RUN, else rom_addr+1 and FETCH.
REQ-025 ACK: counter reaches ACK_TIMEOUT with done_in=0 -> ERR.
REQ-026 ACK: if done_in=1 and the timeout are reached in the same cycle, done_in wins.
REQ-027 rom_addr SHALL never exceed N_WORDS-1; no wrap-around occurs within a boot.
REQ-028 Per-word latency SHALL be 1 (FETCH) + 8 (SHIFT) + k (ACK, k>=1) cycles.
REQ-029 RUN: mode_out=MODE_RUN, core_rst_n=1, done_out pulses once; RUN holds until start=1, which re-enters HOLD (reboot).
REQ-030 ERR: mode_out=MODE_IDLE, core_rst_n=0; exit only via start=1 -> HOLD, with err clearing.
REQ-031 start SHALL be ignored in HOLD, FETCH, SHIFT and ACK.

Reset
REQ-032 rst=1 SHALL asynchronously force: state=IDLE, rom_addr=0, shift_reg=0, counters=0, mode_out=MODE_IDLE, mosi_out=0, core_rst_n=0, busy=0, done_out=0, err=0.
REQ-033 Reset mid-load SHALL abort immediately; no partial-word completion and no done_out.

Structure
REQ-034 SHALL use the shared package tiny_pkg, which holds the mode_t enum (MODE_IDLE=2'b00, MODE_LOAD=2'b01, MODE_RUN=2'b10, MODE_DBG=2'b11) and the boot_state_t enum.
REQ-035 SHALL instantiate one sub-module, bit_shifter: an 8-bit parallel-load, MSB-first serializer with a load/shift enable and a bit counter.

Verification
REQ-036 Bench SHALL cover: reset, then start with ROM=0xA5,0x3C,... and done_in returned 2 cycles after each ACK entry -> mosi_out shows 10100101 on cycles FETCH+1..+8, 16 words loaded, done_out pulses once, mode_out=2'b10.
REQ-037 Bench SHALL cover: done_in held 0 on word 3 -> err=1 exactly ACK_TIMEOUT cycles after ACK entry, core_rst_n=0, rom_addr=3.
REQ-038 Bench SHALL cover: rst asserted during SHIFT of word 5 -> all outputs reach reset values without a clk edge; next start restarts at rom_addr=0.
REQ-039 Bench SHALL cover: start pulsed during SHIFT -> no effect on sequence or timing.
REQ-040 Bench SHALL cover: N_WORDS=1, done_in high on the first ACK cycle -> RUN reached HOLD_CYC+1+8+1 cycles after start.
REQ-041 Bench SHALL cover: done_in rises in the timeout cycle -> RUN or FETCH, never ERR.

Source files
------------

// File: rtl/tiny_pkg.sv
// Shared types for the boot sequencer: processor mode encodings, FSM state
// encoding and the state-to-mode decode used by the top level.
package tiny_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_RUN  = 2'b10,
        MODE_DBG  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_FETCH,
        ST_SHIFT,
        ST_ACK,
        ST_RUN,
        ST_ERR
    } boot_state_t;

    localparam int WORD_W = 8;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;

    function automatic mode_t mode_for_state(input boot_state_t st);
        case (st)
            ST_HOLD, ST_FETCH, ST_SHIFT, ST_ACK: return MODE_LOAD;
            ST_RUN:                              return MODE_RUN;
            default:                             return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/boot_sequencer_bit_shifter.sv
// 8-bit parallel-load, MSB-first serializer with a bit counter that flags
// the final bit of the current word.
module bit_shifter
    import tiny_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [WORD_W-1:0] data_in,
    output logic              bit_out,
    output logic              last_bit
);

    localparam int BCNT_W = $clog2(WORD_W);

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load) begin
            sreg_d = data_in;
            cnt_d  = '0;
        end else if (shift_en) begin
            sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
            cnt_d  = cnt_q + BCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bit_out  = sreg_q[WORD_W-1];
    assign last_bit = (cnt_q == BCNT_W'(WORD_W - 1));

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: holds the core in reset, then streams N_WORDS image words
// serially to it, waiting for a per-word acknowledge with a timeout.
module boot_sequencer
    import tiny_pkg::*;
#(
    parameter int N_WORDS     = 16,
    parameter int ACK_TIMEOUT = 255,
    parameter int HOLD_CYC    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [1:0]        mode_out,
    output logic              mosi_out,
    input  logic              done_in,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done_out,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    boot_state_t       state_q, state_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              load, shift_en;
    logic              bit_out, last_bit;

    bit_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .data_in  (rom_data),
        .bit_out  (bit_out),
        .last_bit (last_bit)
    );

    // Every boot (first, reboot from RUN, or retry from ERR) restarts at word 0.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        tmo_d    = tmo_q;
        addr_d   = addr_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                    addr_d  = '0;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_FETCH;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            ST_FETCH: begin
                load    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (last_bit) begin
                    state_d = ST_ACK;
                    tmo_d   = '0;
                end
            end
            ST_ACK: begin
                tmo_d = tmo_q + CNT_W'(1);
                // An acknowledge arriving in the timeout cycle still counts.
                if (done_in) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            tmo_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr   = addr_q;
    assign mode_out   = mode_for_state(state_q);
    assign mosi_out   = (state_q == ST_SHIFT) && bit_out;
    assign core_rst_n = state_q inside {ST_FETCH, ST_SHIFT, ST_ACK, ST_RUN};
    assign busy       = state_q inside {ST_HOLD, ST_FETCH, ST_SHIFT, ST_ACK};
    assign err        = (state_q == ST_ERR);
    assign done_out   = done_q;

endmodule
